// File: rtl/datatypesPkg.sv
// Shared types for the alignment traceback path: cell directions, walker states, step helper.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package datatypesPkg;

    typedef enum logic [1:0] {
        Nil      = 2'd0,
        Above    = 2'd1,
        Left     = 2'd2,
        Diagonal = 2'd3
    } direction;

    typedef enum logic [1:0] {
        BT_IDLE = 2'd0,
        BT_WALK = 2'd1,
        BT_DONE = 2'd2
    } bt_state_t;

    // Signed position so that a step off the grid edge shows up as a negative index.
    typedef struct packed {
        int row;
        int col;
    } bt_pos_t;

    // Position reached by following one direction pointer from (row, col).
    function automatic bt_pos_t bt_next_pos(input int row, input int col, input direction dir);
        bt_pos_t p;
        p.row = row;
        p.col = col;
        case (dir)
            Above:    p.row = row - 1;
            Left:     p.col = col - 1;
            Diagonal: begin
                p.row = row - 1;
                p.col = col - 1;
            end
            default:  ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bt_step.sv
// One traceback step: next position, last-beat flag and error flag for the current cell.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the step is taken.
module bt_step
    import datatypesPkg::*;
#(
    parameter int RW = 4,
    parameter int CW = 4
) (
    input  logic [RW-1:0] row,
    input  logic [CW-1:0] col,
    input  direction      dir,
    input  logic          local_mode,
    output logic [RW-1:0] next_row,
    output logic [CW-1:0] next_col,
    output logic          last,
    output logic          err
);

    bt_pos_t pos;
    logic    at_origin;
    logic    underflow;
    logic    natural_last;

    // Follow the pointer, then classify the beat: a natural end wins over any error.
    always_comb begin
        pos          = bt_next_pos(int'(row), int'(col), dir);
        next_row     = RW'(pos.row);
        next_col     = CW'(pos.col);
        at_origin    = (row == '0) && (col == '0);
        underflow    = (pos.row < 0) || (pos.col < 0);
        natural_last = local_mode ? ((dir == Nil) || at_origin) : at_origin;
        err          = !natural_last && ((!local_mode && (dir == Nil)) || underflow);
        last         = natural_last || err;
    end

endmodule

// File: rtl/backtrace_stream.sv
// Walks the direction grid from a latched start cell and streams the path as valid/ready beats.
// Latency: first beat the cycle after an accepted start, then one beat per clock while ready is high.
// Backpressure: out_ready low freezes position, count and all outputs until the beat is taken.
module backtrace_stream
    import datatypesPkg::*;
#(
    parameter int len1 = 5,
    parameter int len2 = 5,
    parameter int RW   = $clog2(len1) + 1,
    parameter int CW   = $clog2(len2) + 1,
    parameter int PW   = $clog2(len1 + len2 + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          local_mode,
    input  logic [RW-1:0] start_row,
    input  logic [CW-1:0] start_col,
    input  direction      grid [0:len2-1][0:len1-1],
    output logic          out_valid,
    input  logic          out_ready,
    output direction      out_dir,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [PW-1:0] path_len
);

    bt_state_t     state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          mode_q, mode_d;
    logic          err_q, err_d;
    logic [PW-1:0] len_q, len_d;

    direction      cur_dir;
    logic [RW-1:0] step_row;
    logic [CW-1:0] step_col;
    logic          step_last;
    logic          step_err;

    // Grid lookup at the registered position, written as an explicit mux over all cells.
    always_comb begin
        cur_dir = Nil;
        for (int c = 0; c < len2; c++) begin
            for (int r = 0; r < len1; r++) begin
                if ((col_q == CW'(c)) && (row_q == RW'(r))) begin
                    cur_dir = grid[c][r];
                end
            end
        end
    end

    bt_step #(
        .RW (RW),
        .CW (CW)
    ) u_step (
        .row        (row_q),
        .col        (col_q),
        .dir        (cur_dir),
        .local_mode (mode_q),
        .next_row   (step_row),
        .next_col   (step_col),
        .last       (step_last),
        .err        (step_err)
    );

    // State and datapath registers; reset aborts any walk without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BT_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            len_q   <= len_d;
        end
    end

    // Next-state and output decode; start is only looked at in IDLE.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        mode_d    = mode_q;
        err_d     = err_q;
        len_d     = len_q;
        out_valid = 1'b0;
        out_dir   = Nil;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            BT_IDLE: begin
                if (start) begin
                    len_d = '0;
                    if ((start_row >= RW'(len1)) || (start_col >= CW'(len2))) begin
                        // Bad start cell: report it through the normal done path, no beats.
                        err_d   = 1'b1;
                        state_d = BT_DONE;
                    end else begin
                        err_d   = 1'b0;
                        row_d   = start_row;
                        col_d   = start_col;
                        mode_d  = local_mode;
                        state_d = BT_WALK;
                    end
                end
            end
            BT_WALK: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_dir   = cur_dir;
                out_last  = step_last;
                if (out_ready) begin
                    len_d = len_q + PW'(1);
                    if (step_last) begin
                        err_d   = step_err;
                        state_d = BT_DONE;
                    end else begin
                        row_d = step_row;
                        col_d = step_col;
                    end
                end
            end
            BT_DONE: begin
                done    = 1'b1;
                state_d = BT_IDLE;
            end
            default: begin
                state_d = BT_IDLE;
            end
        endcase
    end

    assign error    = err_q;
    assign path_len = len_q;

endmodule

// File: tb/tb_backtrace_stream.sv
// Directed bench for backtrace_stream: path contents, last flag, errors, backpressure, reset.
// Latency: n/a.
// Backpressure: exercised by toggling out_ready.
module tb_backtrace_stream;
    import datatypesPkg::*;

    localparam int L1 = 5;
    localparam int L2 = 5;

    logic       clk;
    logic       rst;
    logic       start;
    logic       local_mode;
    logic [3:0] start_row;
    logic [3:0] start_col;
    direction   grid [0:L2-1][0:L1-1];
    logic       out_valid;
    logic       out_ready;
    direction   out_dir;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] path_len;

    int checks;
    int failures;

    direction bd [0:15];
    logic     bl [0:15];
    int       nb;
    int       nd;

    backtrace_stream #(.len1(L1), .len2(L2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .local_mode (local_mode),
        .start_row  (start_row),
        .start_col  (start_col),
        .grid       (grid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dir    (out_dir),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .path_len   (path_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_grid();
        for (int c = 0; c < L2; c++)
            for (int r = 0; r < L1; r++)
                grid[c][r] = Nil;
    endtask

    // Called at a negedge; returns at the negedge after the start cycle.
    task automatic do_start(input logic m, input logic [3:0] r, input logic [3:0] c);
        start      = 1'b1;
        local_mode = m;
        start_row  = r;
        start_col  = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records accepted beats and done pulses for a fixed number of cycles.
    task automatic run_walk(input int cycles);
        nb = 0;
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid && out_ready && nb < 16) begin
                bd[nb] = out_dir;
                bl[nb] = out_last;
                nb++;
            end
            if (done) nd++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, busy, done, error, out_last} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got v=%b b=%b d=%b e=%b l=%b, want all 0", out_valid, busy, done, error, out_last);
        end
        checks++;
        if (path_len !== 4'd0 || out_dir !== Nil) begin
            failures++;
            $display("FAIL reset_data: got len=%0d dir=%0d, want 0/0", path_len, out_dir);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_global_diag();
        clear_grid();
        grid[0][0] = Diagonal;
        grid[1][1] = Diagonal;
        grid[2][2] = Diagonal;
        out_ready  = 1'b1;
        do_start(1'b0, 4'd2, 4'd2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL diag_busy: got %b want 1", busy);
        end
        run_walk(8);
        checks++;
        if (nb !== 3) begin
            failures++;
            $display("FAIL diag_beats: got %0d want 3", nb);
        end else begin
            checks++;
            if (bd[0] !== Diagonal || bd[1] !== Diagonal || bd[2] !== Diagonal) begin
                failures++;
                $display("FAIL diag_dirs: got %0d %0d %0d want 3 3 3", bd[0], bd[1], bd[2]);
            end
            checks++;
            if ({bl[0], bl[1], bl[2]} !== 3'b001) begin
                failures++;
                $display("FAIL diag_last: got %b%b%b want 001", bl[0], bl[1], bl[2]);
            end
        end
        checks++;
        if (path_len !== 4'd3 || error !== 1'b0 || nd !== 1) begin
            failures++;
            $display("FAIL diag_status: got len=%0d err=%b dones=%0d want 3/0/1", path_len, error, nd);
        end
    endtask

    task automatic test_global_nil();
        clear_grid();
        out_ready = 1'b1;
        do_start(1'b0, 4'd1, 4'd1);
        run_walk(6);
        checks++;
        if (nb !== 1 || bd[0] !== Nil || bl[0] !== 1'b1) begin
            failures++;
            $display("FAIL gnil_beat: got n=%0d dir=%0d last=%b want 1/0/1", nb, bd[0], bl[0]);
        end
        checks++;
        if (error !== 1'b1 || path_len !== 4'd1 || nd !== 1) begin
            failures++;
            $display("FAIL gnil_status: got err=%b len=%0d dones=%0d want 1/1/1", error, path_len, nd);
        end
    endtask

    task automatic test_local_backpressure();
        direction sd;
        logic     sl;
        logic     prev_stall;
        clear_grid();
        grid[2][2] = Left;
        grid[1][2] = Above;
        grid[1][1] = Nil;
        grid[0][0] = Diagonal;
        do_start(1'b1, 4'd2, 4'd2);
        checks++;
        if (error !== 1'b0 || path_len !== 4'd0) begin
            failures++;
            $display("FAIL lbp_cleared: got err=%b len=%0d want 0/0", error, path_len);
        end
        nb = 0;
        nd = 0;
        prev_stall = 1'b0;
        sd = Nil;
        sl = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_dir !== sd || out_last !== sl) begin
                    failures++;
                    $display("FAIL lbp_hold: got v=%b dir=%0d last=%b want 1/%0d/%b", out_valid, out_dir, out_last, sd, sl);
                end
            end
            out_ready = (i % 2 == 0);
            prev_stall = out_valid && !out_ready;
            sd = out_dir;
            sl = out_last;
            if (out_valid && out_ready && nb < 16) begin
                bd[nb] = out_dir;
                bl[nb] = out_last;
                nb++;
            end
            if (done) nd++;
            @(negedge clk);
        end
        checks++;
        if (nb !== 3) begin
            failures++;
            $display("FAIL lbp_beats: got %0d want 3", nb);
        end else begin
            checks++;
            if (bd[0] !== Left || bd[1] !== Above || bd[2] !== Nil) begin
                failures++;
                $display("FAIL lbp_dirs: got %0d %0d %0d want 2 1 0", bd[0], bd[1], bd[2]);
            end
            checks++;
            if ({bl[0], bl[1], bl[2]} !== 3'b001) begin
                failures++;
                $display("FAIL lbp_last: got %b%b%b want 001", bl[0], bl[1], bl[2]);
            end
        end
        checks++;
        if (path_len !== 4'd3 || error !== 1'b0 || nd !== 1) begin
            failures++;
            $display("FAIL lbp_status: got len=%0d err=%b dones=%0d want 3/0/1", path_len, error, nd);
        end
    endtask

    task automatic test_edge_underflow();
        clear_grid();
        grid[2][0] = Above;
        out_ready  = 1'b1;
        do_start(1'b0, 4'd0, 4'd2);
        run_walk(6);
        checks++;
        if (nb !== 1 || bd[0] !== Above || bl[0] !== 1'b1) begin
            failures++;
            $display("FAIL edge_beat: got n=%0d dir=%0d last=%b want 1/1/1", nb, bd[0], bl[0]);
        end
        checks++;
        if (error !== 1'b1 || path_len !== 4'd1 || nd !== 1) begin
            failures++;
            $display("FAIL edge_status: got err=%b len=%0d dones=%0d want 1/1/1", error, path_len, nd);
        end
    endtask

    task automatic test_out_of_range();
        int vcount;
        clear_grid();
        grid[0][0] = Diagonal;
        out_ready  = 1'b1;
        start      = 1'b1;
        local_mode = 1'b0;
        start_row  = 4'd5;
        start_col  = 4'd0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL oor_done: got done=%b v=%b want 1/0", done, out_valid);
        end
        // Valid start held through the DONE cycle must be dropped.
        start_row = 4'd0;
        @(negedge clk);
        start  = 1'b0;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid || done) vcount++;
            @(negedge clk);
        end
        checks++;
        if (vcount !== 0) begin
            failures++;
            $display("FAIL oor_quiet: got %0d active cycles want 0", vcount);
        end
        checks++;
        if (error !== 1'b1 || path_len !== 4'd0) begin
            failures++;
            $display("FAIL oor_status: got err=%b len=%0d want 1/0", error, path_len);
        end
    endtask

    task automatic test_reset_mid_walk();
        clear_grid();
        for (int k = 0; k < 5; k++) grid[k][k] = Diagonal;
        out_ready = 1'b1;
        do_start(1'b0, 4'd4, 4'd4);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || path_len !== 4'd0) begin
            failures++;
            $display("FAIL rmw_abort: got v=%b b=%b d=%b len=%0d want 0/0/0/0", out_valid, busy, done, path_len);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL rmw_nodone: got %b want 0", done);
        end
        rst = 1'b0;
        @(negedge clk);
        do_start(1'b0, 4'd4, 4'd4);
        // A start while busy (with ready low) must not disturb the walk.
        out_ready  = 1'b0;
        start      = 1'b1;
        local_mode = 1'b1;
        start_row  = 4'd1;
        start_col  = 4'd1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_dir !== Diagonal || path_len !== 4'd0) begin
            failures++;
            $display("FAIL rmw_busy_start: got b=%b dir=%0d len=%0d want 1/3/0", busy, out_dir, path_len);
        end
        out_ready = 1'b1;
        run_walk(10);
        checks++;
        if (nb !== 5 || bl[0] !== 1'b0 || bl[3] !== 1'b0 || bl[4] !== 1'b1 || bd[4] !== Diagonal) begin
            failures++;
            $display("FAIL rmw_path: got n=%0d last0=%b last3=%b last4=%b dir4=%0d want 5/0/0/1/3", nb, bl[0], bl[3], bl[4], bd[4]);
        end
        checks++;
        if (path_len !== 4'd5 || error !== 1'b0 || nd !== 1) begin
            failures++;
            $display("FAIL rmw_status: got len=%0d err=%b dones=%0d want 5/0/1", path_len, error, nd);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        local_mode = 1'b0;
        start_row  = '0;
        start_col  = '0;
        out_ready  = 1'b0;
        clear_grid();
        repeat (2) @(negedge clk);
        test_reset();
        test_global_diag();
        test_global_nil();
        test_local_backpressure();
        test_edge_underflow();
        test_out_of_range();
        test_reset_mid_walk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/backtrace_stream.md
Name: backtrace_stream

Overview:
- Parametrised successor to the alignment traceback walker.
- Walks the direction grid from a latched start cell back to a termination point, one step per accepted beat.
- Streams the path out over a valid/ready interface with a last flag, and reports path length and error status.
- Supports global mode (terminate at cell (0,0)) and local mode (terminate at first Nil). Sits between the score/direction matrix fill stage and the alignment-string formatter.

Parameters:
- len1, 5, sequence 1 length; number of rows in the grid (row index 0..len1-1).
- len2, 5, sequence 2 length; number of columns in the grid (col index 0..len2-1).
- RW, $clog2(len1)+1, row index width.
- CW, $clog2(len2)+1, column index width.
- PW, $clog2(len1+len2+1), path length counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a traceback; honoured only in IDLE.
- local_mode  in  1  0 = global, 1 = local; latched on accepted start.
- start_row  in  RW  starting row; latched on accepted start.
- start_col  in  CW  starting column; latched on accepted start.
- grid  in  direction [0:len2-1][0:len1-1]  direction matrix indexed [col][row]; held stable while busy.
- out_valid  out  1  a path beat is presented.
- out_ready  in  1  consumer accepts the beat.
- out_dir  out  direction  direction of the current cell.
- out_last  out  1  the current beat is the final beat of the path.
- busy  out  1  high in WALK.
- done  out  1  one-cycle pulse when a traceback ends, including error endings.
- error  out  1  sticky status of the last traceback; cleared on the next accepted start.
- path_len  out  PW  number of beats accepted in the last or current traceback.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal row/col/count 0. Reset mid-walk aborts immediately; no done pulse is generated.
- IDLE, start=1:
  - If start_row>=len1 or start_col>=len2: go to DONE with error=1 and emit no beats.
  - Otherwise: latch mode, row and col; clear error and path_len; go to WALK.
  - start while busy is ignored.
- WALK:
  - out_valid=1.
  - out_dir = grid[col][row], combinational from the registered position.
  - A beat transfers when out_valid && out_ready; the position and path_len update on that clock edge. Back-to-back beats run at 1 per clock while out_ready is held high.
  - The outputs stay stable while out_ready=0.
- Moves on transfer:
  - Above: row-1.
  - Left: col-1.
  - Diagonal: row-1 and col-1.
  - path_len+1 on every transfer.
- out_last conditions (combinational):
  - local mode: out_dir==Nil, or row==0 and col==0.
  - global mode: row==0 and col==0.
  - A transfer with out_last=1 goes to DONE with error=0.
- Error conditions, checked on transfer when out_last=0:
  - Global mode and out_dir==Nil.
  - A move that would decrement row or col below 0, e.g. Above at row 0 or Left at col 0.
  - Either case: out_last is forced to 1 for that beat and the walk goes to DONE with error=1.
- DONE: assert done for exactly one cycle, then return to IDLE. busy=0. error and path_len hold until the next accepted start.
- Path length is bounded by len1+len2-1 beats. PW guarantees no counter wrap.
- A start arriving in the DONE cycle is ignored.

Decomposition:
- direction enum {Nil, Above, Left, Diagonal} stays in datatypesPkg.
- Add to datatypesPkg: a bt_state_t enum {BT_IDLE, BT_WALK, BT_DONE} and a function returning the next (row,col) for a direction.
- One sub-module is natural: bt_step, a combinational block that takes row, col, dir and mode and produces next_row, next_col, last and err. This keeps the FSM file small and lets the step logic be unit-tested on its own.

Test Plan:
- Global mode, 3x3, start (2,2):
  - Stimulus: grid Diagonal on the main diagonal, out_ready=1.
  - Required: 3 beats Diagonal, Diagonal, Diagonal; out_last on the 3rd beat; path_len=3; done pulse; error=0.
- Local mode, start (2,2), backpressure:
  - Stimulus: grid[2][2]=Left, grid[1][2]=Above, grid[1][1]=Nil; out_ready toggling 1,0,1,0.
  - Required: beats Left, Above, Nil, with Nil flagged last; outputs hold while out_ready=0; path_len=3; error=0.
- Global mode, start (1,1):
  - Stimulus: grid[1][1]=Nil.
  - Required: 1 beat Nil with last=1; error=1; path_len=1; done pulse.
- Edge underflow, start (0,2):
  - Stimulus: grid[2][0]=Above.
  - Required: 1 beat Above with last=1; error=1.
- Out-of-range start, start_row=len1:
  - Required: no out_valid; done pulse 1 cycle later; error=1; path_len=0.
- Reset mid-walk:
  - Stimulus: assert rst after 2 beats of a 5-beat path.
  - Required: out_valid, busy and done go to 0 immediately; a new start then runs the full path from beat 1.
